// File: rtl/subleq_loader.sv
// ============================================================================
//  Module      : subleq_loader
//  Description : Byte-stream program loader for the subleq32 core. Takes a
//                16-bit little-endian word count followed by little-endian
//                32-bit words and writes them to program memory from address 0.
//                The core is held in reset except after a successful load.
//                Optional trailing checksum word enabled by the macro
//                SUBLEQ_LOADER_CHECKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module subleq_loader #(
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 8192
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iStart,
    input  logic [7:0]        iByte,
    input  logic              iByteValid,
    output logic              oByteReady,
    output logic [ADDR_W-1:0] oMemAddress,
    output logic [31:0]       oMemData,
    output logic              oMemWren,
    output logic              oCoreReset,
    output logic              oBusy,
    output logic              oDone,
    output logic              oError,
    output logic [ADDR_W:0]   oWordCount
);

    localparam logic [16:0] c_depth = 17'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6,
        S_CSUM  = 3'd7
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [15:0]       r_len;
    logic [31:0]       r_word;
    logic [1:0]        r_idx;
    logic [ADDR_W:0]   r_count;

    logic              w_accept;
    logic [15:0]       w_len;
    logic              w_len_bad;
    logic [ADDR_W:0]   w_count_inc;
    logic              w_last;
    logic              w_word_end;

`ifdef SUBLEQ_LOADER_CHECKSUM_EN
    logic [31:0]       r_sum;
    logic [31:0]       w_word_full;
    logic              w_sum_ok;
`endif

    assign w_accept    = iByteValid && oByteReady;
    assign w_len       = {iByte, r_len[7:0]};
    assign w_len_bad   = (w_len == 16'd0) || ({1'b0, w_len} > c_depth);
    assign w_count_inc = r_count + 1'b1;
    // Count never exceeds DEPTH, so widening to the header width is lossless.
    assign w_last      = (16'(w_count_inc) == r_len);
    assign w_word_end  = w_accept && (r_idx == 2'd3);

`ifdef SUBLEQ_LOADER_CHECKSUM_EN
    assign w_word_full = {iByte, r_word[23:0]};
    assign w_sum_ok    = ((r_sum + w_word_full) == 32'd0);
`endif

    // Address follows the running count; data is the assembled word.
    assign oMemAddress = r_count[ADDR_W-1:0];
    assign oMemData    = r_word;
    assign oWordCount  = r_count;

    // State register.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_next     = r_state;
        oByteReady = 1'b0;
        oMemWren   = 1'b0;
        oCoreReset = 1'b1;
        oBusy      = 1'b0;
        oDone      = 1'b0;
        oError     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (iStart) w_next = S_LEN0;
            end
            S_LEN0: begin
                oByteReady = 1'b1;
                oBusy      = 1'b1;
                if (w_accept) w_next = S_LEN1;
            end
            S_LEN1: begin
                oByteReady = 1'b1;
                oBusy      = 1'b1;
                if (w_accept) w_next = w_len_bad ? S_ERROR : S_DATA;
            end
            S_DATA: begin
                oByteReady = 1'b1;
                oBusy      = 1'b1;
                if (w_word_end) w_next = S_WRITE;
            end
            S_WRITE: begin
                oMemWren = 1'b1;
                oBusy    = 1'b1;
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
                w_next   = w_last ? S_CSUM : S_DATA;
`else
                w_next   = w_last ? S_DONE : S_DATA;
`endif
            end
            S_DONE: begin
                oCoreReset = 1'b0;
                oDone      = 1'b1;
                if (iStart) w_next = S_LEN0;
            end
            S_ERROR: begin
                oError = 1'b1;
                if (iStart) w_next = S_LEN0;
            end
            S_CSUM: begin
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
                oByteReady = 1'b1;
                oBusy      = 1'b1;
                if (w_word_end) w_next = w_sum_ok ? S_DONE : S_ERROR;
`else
                w_next = S_IDLE;
`endif
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Length capture, byte assembly and word counting.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_len   <= 16'd0;
            r_word  <= 32'd0;
            r_idx   <= 2'd0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (iStart) begin
                        r_idx   <= 2'd0;
                        r_count <= '0;
                    end
                end
                S_LEN0: begin
                    if (w_accept) r_len[7:0] <= iByte;
                end
                S_LEN1: begin
                    if (w_accept) r_len <= w_len;
                end
                S_DATA, S_CSUM: begin
                    if (w_accept) begin
                        r_word[8*r_idx +: 8] <= iByte;
                        r_idx                <= r_idx + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_count <= w_count_inc;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SUBLEQ_LOADER_CHECKSUM_EN
    // Modulo-2^32 sum of every word written in the current load.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_sum <= 32'd0;
        end else if ((r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR) && iStart) begin
            r_sum <= 32'd0;
        end else if (r_state == S_WRITE) begin
            r_sum <= r_sum + r_word;
        end
    end
`endif

endmodule

`default_nettype wire
